// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver (DATA_BITS data, optional
// even/odd parity, 1 or 2 stop bits). It samples on the shared
// oversampling baud tick, majority-votes each bit from three samples and
// reports parity, framing and break status per frame.
//
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   rx          serial line, idle high, asynchronous to clk
//   b_tick      one-clk pulse at baud * OVERSAMPLE
//   rx_data     last received word (first line bit in bit 0)
//   rx_done     one-clk pulse when a frame completes
//   parity_err  parity mismatch in the last frame
//   frame_err   a stop bit resolved to 0 in the last frame
//   break_det   last frame all-zero including parity and stop
//   busy        receiver is inside a frame (through the rx_done clk)
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 b_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE - 3);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE - 2);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_DLAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_SLAST = BW'(STOP_BITS - 1);
    localparam logic          ODD     = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state, state_n;
    logic                 rx_q, rx_s;
    logic [TW-1:0]        tcnt;
    logic [BW-1:0]        bcnt;
    logic                 smp0, smp1;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc, perr_acc, ferr_acc, pbit;
    logic                 bit_end, bit_val, done_n, start_det, fe_final;

    // Synchroniser resets to idle-high so reset release is not a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_q <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_q <= rx;
            rx_s <= rx_q;
        end
    end

    // Two samples are stored; the third is the live rx_s at the resolve tick.
    assign bit_val  = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
    assign bit_end  = b_tick && (tcnt == T_LAST);
    assign start_det = (state == S_IDLE) && (state_n == S_START);
    assign fe_final = ferr_acc | ~bit_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        case (state)
            S_IDLE:   if (b_tick && !rx_s) state_n = S_START;
            S_START:  if (b_tick && tcnt == T_MID) state_n = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (bit_end && bcnt == B_DLAST)
                          state_n = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_n = S_STOP;
            // Leave at mid-stop so the next start edge is not missed.
            S_STOP:   if (bit_end && bcnt == B_SLAST) begin
                          state_n = S_IDLE;
                          done_n  = 1'b1;
                      end
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt       <= '0;
            bcnt       <= '0;
            smp0       <= 1'b1;
            smp1       <= 1'b1;
            shreg      <= '0;
            par_acc    <= 1'b0;
            perr_acc   <= 1'b0;
            ferr_acc   <= 1'b0;
            pbit       <= 1'b0;
            rx_data    <= '0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Bit periods are measured from mid-start, so tcnt restarts there.
            if (b_tick) begin
                if (state == S_IDLE || (state == S_START && tcnt == T_MID) || tcnt == T_LAST)
                    tcnt <= '0;
                else
                    tcnt <= tcnt + TW'(1);
                if (tcnt == T_S0) smp0 <= rx_s;
                if (tcnt == T_S1) smp1 <= rx_s;
            end

            if (state == S_IDLE)
                bcnt <= '0;
            else if (bit_end)
                bcnt <= (state_n != state) ? '0 : bcnt + BW'(1);

            if (start_det) begin
                par_acc  <= 1'b0;
                perr_acc <= 1'b0;
                ferr_acc <= 1'b0;
                pbit     <= 1'b0;
            end

            if (bit_end) begin
                case (state)
                    S_DATA: begin
                        shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ bit_val;
                    end
                    S_PARITY: begin
                        pbit     <= bit_val;
                        perr_acc <= par_acc ^ bit_val ^ ODD;
                    end
                    S_STOP:  ferr_acc <= fe_final;
                    default: ;
                endcase
            end

            rx_done <= done_n;
            if (done_n) begin
                rx_data    <= shreg;
                parity_err <= perr_acc;
                frame_err  <= fe_final;
                break_det  <= fe_final && (shreg == '0) && (!pbit || PARITY == 0);
            end

            // Held through the rx_done clk, then follows the state.
            busy <= (state_n != S_IDLE) | done_n;
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) at OVERSAMPLE=8
// share clock, reset and baud tick. Expected frames are queued as they are
// sent and compared when each instance pulses rx_done.
module tb_uart_rx_cfg;
    localparam int OS = 8;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_tick = 1'b0;
    logic [2:0] rx = 3'b111;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [2:0] done, perr, ferr, brk, busy;
    int         tdiv = 0;

    int   checks = 0;
    int   fails = 0;
    int   ndone[3] = '{0, 0, 0};
    exp_t q0[$], q1[$], q2[$];
    int   cfg_nd[3] = '{8, 8, 7};
    int   cfg_pm[3] = '{0, 1, 2};
    int   cfg_ns[3] = '{1, 1, 2};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tdiv   <= (tdiv == 2) ? 0 : tdiv + 1;
        b_tick <= (tdiv == 2);
    end

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .rx(rx[0]), .b_tick(b_tick), .rx_data(d0), .rx_done(done[0]),
        .parity_err(perr[0]), .frame_err(ferr[0]), .break_det(brk[0]), .busy(busy[0]));
    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .rx(rx[1]), .b_tick(b_tick), .rx_data(d1), .rx_done(done[1]),
        .parity_err(perr[1]), .frame_err(ferr[1]), .break_det(brk[1]), .busy(busy[1]));
    uart_rx_cfg #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .rx(rx[2]), .b_tick(b_tick), .rx_data(d2), .rx_done(done[2]),
        .parity_err(perr[2]), .frame_err(ferr[2]), .break_det(brk[2]), .busy(busy[2]));

    // Scoreboard: pop on rx_done, and require busy to drop on the next clk.
    logic [2:0] pend_busy = 3'b000;
    exp_t       e;
    logic [8:0] got;
    logic       have;
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) begin
                ndone[i]++;
                got  = (i == 0) ? {1'b0, d0} : (i == 1) ? {1'b0, d1} : {2'b00, d2};
                have = 1'b1;
                case (i)
                    0: if (q0.size() > 0) e = q0.pop_front(); else have = 1'b0;
                    1: if (q1.size() > 0) e = q1.pop_front(); else have = 1'b0;
                    default: if (q2.size() > 0) e = q2.pop_front(); else have = 1'b0;
                endcase
                checks++;
                if (!have) begin
                    fails++;
                    $display("FAIL unexpected_rx_done dut%0d data=%h", i, got);
                end else begin
                    if (got !== e.d) begin
                        fails++;
                        $display("FAIL rx_data dut%0d got=%h exp=%h", i, got, e.d);
                    end
                    checks++;
                    if (perr[i] !== e.pe) begin
                        fails++;
                        $display("FAIL parity_err dut%0d got=%b exp=%b", i, perr[i], e.pe);
                    end
                    checks++;
                    if (ferr[i] !== e.fe) begin
                        fails++;
                        $display("FAIL frame_err dut%0d got=%b exp=%b", i, ferr[i], e.fe);
                    end
                    checks++;
                    if (brk[i] !== e.bk) begin
                        fails++;
                        $display("FAIL break_det dut%0d got=%b exp=%b", i, brk[i], e.bk);
                    end
                end
                checks++;
                if (busy[i] !== 1'b1) begin
                    fails++;
                    $display("FAIL busy_at_done dut%0d got=%b exp=1", i, busy[i]);
                end
                pend_busy[i] = 1'b1;
            end else if (pend_busy[i]) begin
                pend_busy[i] = 1'b0;
                checks++;
                if (busy[i] !== 1'b0) begin
                    fails++;
                    $display("FAIL busy_after_done dut%0d got=%b exp=0", i, busy[i]);
                end
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            do @(posedge clk); while (b_tick !== 1'b1);
        end
    endtask

    // Drive one frame on rx[idx]; bit gl (if >=0) gets a 1-tick inversion
    // that lands on the middle of the three vote samples.
    task automatic send_frame(input int idx, input logic [8:0] d, input logic pb,
                              input logic sv, input int gl, input int idle);
        logic [15:0] f;
        int p;
        exp_t x;
        logic [8:0] dm;
        f = 16'hFFFF;
        f[0] = 1'b0;
        p = 1;
        dm = d & 9'((1 << cfg_nd[idx]) - 1);
        for (int i = 0; i < cfg_nd[idx]; i++) begin f[p] = dm[i]; p++; end
        if (cfg_pm[idx] != 0) begin f[p] = pb; p++; end
        for (int i = 0; i < cfg_ns[idx]; i++) begin f[p] = sv; p++; end
        x.d  = dm;
        x.pe = (cfg_pm[idx] == 0) ? 1'b0 : ((^dm) ^ pb ^ (cfg_pm[idx] == 2));
        x.fe = ~sv;
        x.bk = ~sv && (dm == 9'd0) && (cfg_pm[idx] == 0 || pb == 1'b0);
        case (idx)
            0: q0.push_back(x);
            1: q1.push_back(x);
            default: q2.push_back(x);
        endcase
        for (int b = 0; b < p; b++) begin
            rx[idx] = f[b];
            if (b == gl) begin
                wait_ticks(3);
                rx[idx] = ~f[b];
                wait_ticks(1);
                rx[idx] = f[b];
                wait_ticks(OS - 4);
            end else begin
                wait_ticks(OS);
            end
        end
        rx[idx] = 1'b1;
        wait_ticks(idle);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++;
        if ({done, perr, ferr, brk, busy} !== 15'd0) begin
            fails++;
            $display("FAIL reset_status got=%b exp=0", {done, perr, ferr, brk, busy});
        end
        checks++;
        if ({d0, d1, d2} !== 23'd0) begin
            fails++;
            $display("FAIL reset_data got=%h exp=0", {d0, d1, d2});
        end
        rst = 1'b0;
        wait_ticks(2);
    endtask

    task automatic test_basic();
        send_frame(0, 9'h0A5, 1'b0, 1'b1, -1, OS);
        checks++;
        if (ndone[0] !== 1) begin
            fails++;
            $display("FAIL basic_done_count got=%0d exp=1", ndone[0]);
        end
    endtask

    task automatic test_parity();
        send_frame(1, 9'h03C, 1'b1, 1'b1, -1, OS);
        send_frame(1, 9'h03C, 1'b0, 1'b1, -1, OS);
    endtask

    task automatic test_framing();
        send_frame(0, 9'h055, 1'b0, 1'b0, -1, OS);
        send_frame(0, 9'h000, 1'b0, 1'b0, -1, 2 * OS);
    endtask

    task automatic test_false_start();
        int n;
        n = ndone[0];
        rx[0] = 1'b0;
        wait_ticks(4);
        rx[0] = 1'b1;
        wait_ticks(2 * OS);
        checks++;
        if (busy[0] !== 1'b0 || ndone[0] !== n) begin
            fails++;
            $display("FAIL false_start busy=%b dones=%0d exp busy=0 dones=%0d", busy[0], ndone[0], n);
        end
        send_frame(0, 9'h081, 1'b0, 1'b1, -1, OS);
    endtask

    task automatic test_back_to_back();
        send_frame(2, 9'h07F, 1'b0, 1'b1, -1, 0);
        send_frame(2, 9'h000, 1'b1, 1'b1, -1, OS);
        checks++;
        if (ndone[2] !== 2) begin
            fails++;
            $display("FAIL b2b_done_count got=%0d exp=2", ndone[2]);
        end
        send_frame(2, 9'h02A, 1'b0, 1'b1, 3, OS);
        send_frame(0, 9'h0C3, 1'b0, 1'b1, 5, OS);
    endtask

    task automatic test_reset_midframe();
        int n;
        n = ndone[0];
        rx[0] = 1'b0;
        wait_ticks(OS);
        rx[0] = 1'b1;
        wait_ticks(3 * OS);
        checks++;
        if (busy[0] !== 1'b1) begin
            fails++;
            $display("FAIL busy_midframe got=%b exp=1", busy[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({d0, done[0], perr[0], ferr[0], brk[0], busy[0]} !== 13'd0) begin
            fails++;
            $display("FAIL reset_midframe got=%h exp=0", {d0, done[0], perr[0], ferr[0], brk[0], busy[0]});
        end
        rst = 1'b0;
        wait_ticks(8 * OS);
        checks++;
        if (ndone[0] !== n) begin
            fails++;
            $display("FAIL aborted_frame_done got=%0d exp=%0d", ndone[0], n);
        end
        send_frame(0, 9'h012, 1'b0, 1'b1, -1, OS);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_false_start();
        test_back_to_back();
        test_reset_midframe();
        wait_ticks(2 * OS);
        checks++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            fails++;
            $display("FAIL missing_frames pending=%0d/%0d/%0d exp=0", q0.size(), q1.size(), q2.size());
        end
        checks++;
        if (ndone[0] !== 6 || ndone[1] !== 2 || ndone[2] !== 3) begin
            fails++;
            $display("FAIL done_counts got=%0d/%0d/%0d exp=6/2/3", ndone[0], ndone[1], ndone[2]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, the next generation of the fixed 8N1 receiver. It deserialises frames with configurable data width, parity and stop bits, using the shared oversampling baud tick. It adds an input synchroniser, 3-sample majority voting, false-start rejection, and per-frame parity, framing and break status. It sits between the pad-side `rx` line and the RX FIFO write port.

## Interface
- DATA_BITS, 8: data bits per frame; legal 5..9.
- OVERSAMPLE, 16: b_tick pulses per bit; even, ≥8.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rx  in  1  serial input, idle high, asynchronous to clk
- b_tick  in  1  one-clk pulse at baud×OVERSAMPLE
- rx_data  out  DATA_BITS  last received word, LSB first on the line
- rx_done  out  1  one-clk pulse, frame complete
- parity_err  out  1  parity mismatch in last frame (0 when PARITY=0)
- frame_err  out  1  a stop bit sampled 0 in last frame
- break_det  out  1  last frame all-zero incl. parity and stop
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Input path: 2-flop synchroniser, both flops reset to 1. All decisions use the synchronised value rx_s.
- Counters: tick counter tcnt is $clog2(OVERSAMPLE) bits wide and advances only on b_tick. Bit counter is $clog2(DATA_BITS+1) bits wide.
- Shift register: DATA_BITS wide. A running XOR accumulates the received data bits.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE → START: b_tick with rx_s=0. Clear tcnt.
- START:
  - At the b_tick with tcnt=OVERSAMPLE/2−1, sample rx_s.
  - If rx_s=1, the start is false: go to IDLE with no outputs changed.
  - Otherwise clear tcnt and go to DATA.
- Bit sampling (DATA, PARITY, STOP):
  - Each bit lasts OVERSAMPLE ticks, measured from mid-start.
  - rx_s is captured at tcnt = OVERSAMPLE−3, −2, −1; the bit value is the majority of the three.
  - At tcnt=OVERSAMPLE−1 the bit is resolved and tcnt wraps to 0.
- DATA:
  - Each resolved bit is shifted in at the MSB, shifting right, so the first bit lands in bit 0 after DATA_BITS shifts.
  - After bit DATA_BITS−1, go to PARITY if PARITY≠0, else STOP.
- PARITY: resolve one bit. Error = XOR(data) ^ bit ^ (PARITY==2).
- STOP:
  - Resolve STOP_BITS bits. Any resolved 0 sets the frame error.
  - On the last stop bit resolution, go directly to IDLE (mid-stop) so that a following start edge is caught.
- Completion (same clk edge as last stop resolution):
  - rx_data ← shift register; parity_err, frame_err, break_det registered.
  - rx_done=1 for exactly that one clk.
  - Status outputs hold until the next rx_done.
- break_det = frame_err & data==0 & (parity bit==0 or PARITY==0).
- A frame with errors still produces rx_done and rx_data.
- rx changes are ignored while b_tick=0.

## Timing
- Reset values: rx_data=0, rx_done=0, parity_err=0, frame_err=0, break_det=0, busy=0, state IDLE.
- Mid-frame reset aborts the frame immediately with no rx_done.
- Synchroniser latency is 2 clk; the start edge is detected on the first b_tick after that.
- rx_done rises on the clk edge registering the b_tick at which the last stop bit's tcnt=OVERSAMPLE−1. Delay from detected start edge = (OVERSAMPLE/2) + (DATA_BITS + P + STOP_BITS)·OVERSAMPLE ticks, where P = (PARITY≠0).
- busy is high from the clk after start detection through the clk that pulses rx_done, and low on the next.
- Back-to-back frames: a new start can be accepted on the first b_tick after rx_done.
- No backpressure exists; the consumer must take rx_data on rx_done.

## Test plan
- DATA_BITS=8, PARITY=0, STOP_BITS=1: send 0xA5 → one rx_done, rx_data=0xA5, all errors 0, busy low the clk after.
- PARITY=1: send 0x3C with parity bit 1 (wrong) → rx_data=0x3C, parity_err=1. Next frame 0x3C with parity bit 0 → parity_err=0.
- Stop bit driven 0, data 0x55 → frame_err=1, break_det=0. Hold rx low for a full frame → rx_data=0, frame_err=1, break_det=1.
- rx low for 4 ticks then high → no rx_done, busy returns to 0, a subsequent valid 0x81 is received correctly.
- DATA_BITS=7, STOP_BITS=2, PARITY=2: back-to-back 0x7F, 0x00 → two rx_done pulses with correct data. A 1-tick glitch at mid-bit does not corrupt the data (majority vote).
- Assert rst during DATA of a 0xFF frame → outputs at reset values, no rx_done. The next frame 0x12 is received correctly.
